// File: rtl/md_pkg.sv
// Shared constants and encodings for the multiply/divide unit.
package md_pkg;

  localparam int WIDTH    = 32;
  localparam int ITER_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  // Magnitude of a value; only negates when the operation is signed.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between a requester and md_unit.
interface md_if;
  import md_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, x, y, mthi, mtlo, wdata,
                  input  busy, done, div0, hi, lo);
  modport slave  (input  start, op, x, y, mthi, mtlo, wdata,
                  output busy, done, div0, hi, lo);

endinterface

// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit with hi/lo result registers.
// state | meaning: IDLE wait for start / accept mthi,mtlo; CALC one bit per edge;
// FIX apply signs and write hi/lo; DONE one-cycle result pulse.
module md_unit
  import md_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic clk,
  input  logic rst_n,
  md_if.slave  bus
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [2*WIDTH-1:0] ONE_D = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               busy_r;
  logic               done_r;
  logic               div0_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sgn_in;
  logic [WIDTH-1:0]   ax;
  logic [WIDTH-1:0]   ay;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_res;
  logic [2*WIDTH-1:0] calc_next;

  always_comb begin
    sgn_in = bus.op[0];
    ax     = abs_val(bus.x, sgn_in);
    ay     = abs_val(bus.y, sgn_in);
  end

  // One 33-bit adder: add for multiply, subtract (via carry-in) for divide.
  always_comb begin
    add_a   = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b   = is_div ? ~{1'b0, opnd} : (acc[0] ? {1'b0, opnd} : '0);
    add_cin = is_div;
    add_res = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    if (is_div) begin
      // Carry out set means the trial subtraction did not borrow.
      if (add_res[WIDTH+1])
        calc_next = {add_res[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        calc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      calc_next = {add_res[WIDTH:0], acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.op[1] && (bus.y == '0)) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
              div0_r <= 1'b1;
            end else begin
              state  <= ST_CALC;
              busy_r <= 1'b1;
              cnt    <= '0;
              acc    <= {{WIDTH{1'b0}}, ax};
              opnd   <= ay;
              is_div <= bus.op[1];
              neg_q  <= sgn_in & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
              neg_r  <= sgn_in & bus.op[1] & bus.x[WIDTH-1];
            end
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        ST_CALC: begin
          acc <= calc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div) begin
            lo_r <= neg_q ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
            hi_r <= neg_r ? (~acc[2*WIDTH-1:WIDTH] + ONE_W) : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi_r, lo_r} <= neg_q ? (~acc + ONE_D) : acc;
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random operations.
module tb_md_unit;
  import md_pkg::*;

  localparam int N_ITER = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_z;

  md_if bus ();

  md_unit #(.ITER(N_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; divide by zero leaves hi/lo alone.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    exp_z = 1'b0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        {exp_hi, exp_lo} = p;
      end
      2'b01: begin
        p = sa * sb;
        {exp_hi, exp_lo} = p;
      end
      2'b10: begin
        if (b == 0) exp_z = 1'b1;
        else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      default: begin
        if (b == 0) exp_z = 1'b1;
        else begin
          exp_lo = 32'(sa / sb);
          exp_hi = 32'(sa % sb);
        end
      end
    endcase
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // Called and returns at a falling edge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, input bit with_strobe);
    int n;
    int busy_cnt;
    bus.start = 1'b1;
    bus.op    = op;
    bus.x     = a;
    bus.y     = b;
    if (with_strobe) begin
      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = $urandom;
    end
    model_op(op, a, b);
    @(negedge clk);
    clear_inputs();
    bus.x = $urandom;
    bus.y = $urandom;
    if (exp_z) begin
      check_val("z_done", 64'(bus.done), 64'd1);
      check_val("z_div0", 64'(bus.div0), 64'd1);
      check_val("z_busy", 64'(bus.busy), 64'd0);
      check_val("z_hi", 64'(bus.hi), 64'(exp_hi));
      check_val("z_lo", 64'(bus.lo), 64'(exp_lo));
      @(negedge clk);
      check_val("z_done_clr", 64'(bus.done), 64'd0);
      return;
    end
    n        = 1;
    busy_cnt = 0;
    while (!bus.done && n < 80) begin
      if (bus.busy) busy_cnt++;
      if (scramble && n < 6) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.x     = $urandom;
        bus.y     = $urandom;
        bus.mthi  = 1'b1;
        bus.mtlo  = ($urandom_range(0, 1) == 1);
        bus.wdata = $urandom;
      end else begin
        clear_inputs();
      end
      @(negedge clk);
      n++;
    end
    clear_inputs();
    check_val("done_latency", 64'(n), 64'(N_ITER + 2));
    check_val("busy_cycles", 64'(busy_cnt), 64'(N_ITER + 1));
    check_val("hi", 64'(bus.hi), 64'(exp_hi));
    check_val("lo", 64'(bus.lo), 64'(exp_lo));
    check_val("div0_clear", 64'(bus.div0), 64'd0);
    @(negedge clk);
    check_val("done_pulse", 64'(bus.done), 64'd0);
  endtask

  task automatic write_hilo(input bit h_en, input bit l_en, input logic [31:0] d);
    bus.mthi  = h_en;
    bus.mtlo  = l_en;
    bus.wdata = d;
    if (h_en) exp_hi = d;
    if (l_en) exp_lo = d;
    @(negedge clk);
    clear_inputs();
    check_val("mt_hi", 64'(bus.hi), 64'(exp_hi));
    check_val("mt_lo", 64'(bus.lo), 64'(exp_lo));
  endtask

  logic [31:0] bnd [5];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return bnd[$urandom_range(0, 4)];
      1: return 32'($urandom_range(0, 20));
      2: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_seen;
    logic [31:0] a;
    logic [31:0] b;
    n_cmp  = 0;
    n_bad  = 0;
    exp_hi = '0;
    exp_lo = '0;
    bnd    = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    rst_n  = 1'b0;
    clear_inputs();
    bus.op    = '0;
    bus.x     = '0;
    bus.y     = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_div0", 64'(bus.div0), 64'd0);
    check_val("rst_hi", 64'(bus.hi), 64'd0);
    check_val("rst_lo", 64'(bus.lo), 64'd0);

    // Release reset and request on the same cycle: first rising edge accepts.
    rst_n = 1'b1;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_val("multu_max_hi", 64'(exp_hi), 64'h0000_0000_FFFF_FFFE);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    write_hilo(1'b0, 1'b1, 32'h0000_1234);
    do_op(OP_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
    write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
    do_op(OP_DIV, 32'd9, 32'd0, 1'b0, 1'b1);

    do_op(OP_MULTU, 32'd3, 32'd4, 1'b1, 1'b0);

    // Reset mid-calculation.
    write_hilo(1'b1, 1'b1, 32'h5555_AAAA);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.x     = 32'd3;
    bus.y     = 32'd4;
    @(negedge clk);
    clear_inputs();
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_hi", 64'(bus.hi), 64'd0);
    check_val("abort_lo", 64'(bus.lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check_val("abort_no_done", 64'(done_seen), 64'd0);
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 5) == 0)
        write_hilo($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      do_op(2'($urandom_range(0, 3)), a, b,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter: ITER, default 32, number of iteration cycles (one result bit per cycle).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only when idle.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 x  input  32  multiplicand or dividend, captured at the accepting edge.
REQ-007 y  input  32  multiplier or divisor, captured at the accepting edge.
REQ-008 mthi / mtlo  input  1 each  direct-write strobes for hi / lo.
REQ-009 wdata  input  32  data for mthi/mtlo.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-012 div0  output  1  valid with done; divide by zero occurred.
REQ-013 hi / lo  output  32 each  result registers.

Function
REQ-014 States: IDLE, CALC, FIX, DONE; DONE returns to IDLE after one cycle.
REQ-015 IDLE with start=1: capture op, |x| and |y| (abs only for signed ops), result signs, cnt=0; go to CALC.
REQ-016 CALC: shift-add multiply or restoring divide, one bit per edge; after ITER edges go to FIX.
REQ-017 FIX: apply signs, write hi/lo, go to DONE; new hi/lo appear at the 33rd edge after the accepting edge.
REQ-018 done=1 only in DONE; busy=1 in CALC and FIX, 0 in IDLE and DONE.
REQ-019 MULT/MULTU: {hi,lo} = 64-bit product; signed product sign = x[31]^y[31].
REQ-020 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero; remainder sign follows the dividend.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
REQ-022 Divide with y==0: go from IDLE directly to DONE; hi/lo unchanged; div0=1 during done.
REQ-023 div0=0 for every other done.
REQ-024 start while busy or in DONE: ignored; captured operands unaffected.
REQ-025 mthi/mtlo in IDLE or DONE without start: hi or lo <= wdata at that edge; both strobes may act together.
REQ-026 mthi/mtlo while busy: ignored.
REQ-027 start and mthi/mtlo on the same edge in IDLE: start wins; strobes dropped.
REQ-028 x/y changes after the accepting edge do not affect the result.

Reset
REQ-029 rst_n=0 forces, asynchronously: state IDLE, cnt=0, busy=0, done=0, div0=0, hi=0, lo=0, all working registers 0.
REQ-030 Reset mid-operation aborts with no done pulse.
REQ-031 First start accepted is the first rising edge with rst_n=1.

Structure
REQ-032 Shared package md_pkg holds: op encodings, state encoding, ITER default, 32-bit width constant.
REQ-033 Single module, no sub-module; datapath is a 64-bit shift register plus a 33-bit adder/subtractor shared by multiply and divide.

Verification
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start cycle; busy high 33 cycles.
REQ-035 MULT 0xFFFFFFFD*5 (-3*5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 Divide results:
- DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 mtlo 0x1234, then DIVU 5/0 -> done in the cycle after the accepting edge; div0=1; lo=0x1234; hi unchanged.
REQ-038 Start MULTU 3*4, then start and mthi=0xAAAA during CALC -> both ignored; result hi=0, lo=12; single done pulse.
REQ-039 rst_n low at CALC cycle 10 -> busy=0, hi=lo=0 immediately; no done; next start then completes normally.
